// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin arbiter sharing one FIFO push port between
// NUM_REQ producers. A local credit counter tracks free FIFO slots so a push
// is only issued when the FIFO is known to have room. All outputs except
// 'full' are registered and drive the FIFO push/tail inputs directly.
//
// Optional feature macro: FIFO_ARB_PRIO0_EN
//   defined   -> producer 0 has strict priority; producers 1..NUM_REQ-1
//                share the remaining slots round-robin.
//   undefined -> pure round-robin over all producers.
module fifo_push_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 23,
  parameter int BUFFER_DEPTH = 23,
  parameter int CREDIT_WIDTH = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_tail,
  input  logic                          fifo_pull,
  output logic [CREDIT_WIDTH-1:0]       free_slots,
  output logic                          full
);

  localparam int                       IDX_W    = $clog2(NUM_REQ);
  localparam logic [CREDIT_WIDTH-1:0]  DEPTH_C  = CREDIT_WIDTH'(BUFFER_DEPTH);
  localparam logic [IDX_W-1:0]         LAST_RST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]        last_q;
  logic [CREDIT_WIDTH-1:0] credit_q;

  logic [DATA_WIDTH-1:0]   words [NUM_REQ];
  logic [NUM_REQ-1:0]      eligible;
  logic                    found;
  logic                    upd_last;
  logic [IDX_W-1:0]        winner;
  logic [IDX_W-1:0]        sel;
  int                      idx;
  logic                    issue;
  logic                    pull_ok;

  // Split the flat producer bus into one word per producer.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Winner selection: the grant register doubles as the mask, so a producer
  // granted last cycle sits out this one and its stale request is not re-pushed.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    eligible = req & ~grant;
    found    = 1'b0;
    upd_last = 1'b0;
    winner   = last_q;
    sel      = '0;
    idx      = 0;
`ifdef FIFO_ARB_PRIO0_EN
    if (eligible[0]) begin
      // Strict-priority win; the round-robin pointer is left alone.
      found  = 1'b1;
      winner = '0;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(last_q) + k) % NUM_REQ;
        sel = IDX_W'(idx);
        if (!found && idx != 0 && eligible[sel]) begin
          found    = 1'b1;
          upd_last = 1'b1;
          winner   = sel;
        end
      end
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      sel = IDX_W'(idx);
      if (!found && eligible[sel]) begin
        found    = 1'b1;
        upd_last = 1'b1;
        winner   = sel;
      end
    end
`endif
    issue   = found && (credit_q != '0);
    pull_ok = fifo_pull && (credit_q != DEPTH_C);
  end

  // Registered push port: grant pulse, push strobe, tail word and RR pointer.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      grant     <= '0;
      fifo_push <= 1'b0;
      fifo_tail <= '0;
      last_q    <= LAST_RST;
    end else if (issue) begin
      grant     <= NUM_REQ'(1) << winner;
      fifo_push <= 1'b1;
      fifo_tail <= words[winner];
      if (upd_last) last_q <= winner;
    end else begin
      grant     <= '0;
      fifo_push <= 1'b0;
    end
  end

  // Credit counter: a push consumes a slot, an accepted pull returns one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      credit_q <= DEPTH_C;
    end else if (issue && !pull_ok) begin
      credit_q <= credit_q - CREDIT_WIDTH'(1);
    end else if (pull_ok && !issue) begin
      credit_q <= credit_q + CREDIT_WIDTH'(1);
    end
  end

  assign free_slots = credit_q;
  assign full       = (credit_q == '0);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed bench for fifo_push_arbiter
// (NUM_REQ=4, DATA_WIDTH=23, BUFFER_DEPTH=23).
module tb_fifo_push_arbiter;

  localparam int NR = 4;
  localparam int DW = 23;
  localparam int BD = 23;
  localparam int CW = 5;

  logic             clock;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    grant;
  logic             fifo_push;
  logic [DW-1:0]    fifo_tail;
  logic             fifo_pull;
  logic [CW-1:0]    free_slots;
  logic             full;

  int vectors     = 0;
  int miscompares = 0;

  fifo_push_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .BUFFER_DEPTH(BD), .CREDIT_WIDTH(CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .fifo_push  (fifo_push),
    .fifo_tail  (fifo_tail),
    .fifo_pull  (fifo_pull),
    .free_slots (free_slots),
    .full       (full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] word(input int i, input int k);
    return DW'(i * 1000 + k);
  endfunction

  task automatic set_word(input int i, input logic [DW-1:0] w);
    req_data[i*DW +: DW] = w;
  endtask

  initial begin
    int cnt [NR];
    int p;
    int exp_seq [4];

    reset     = 1'b1;
    req       = '0;
    req_data  = '0;
    fifo_pull = 1'b0;
    #2 reset  = 1'b0;
    #1;
    // Reset state.
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_push",  32'(fifo_push), 32'd0);
    check("rst_tail",  32'(fifo_tail), 32'd0);
    check("rst_free",  32'(free_slots), 32'd23);
    check("rst_full",  32'(full), 32'd0);
    tick();
    tick();
    reset = 1'b1;

    // All four producers request; each swaps its word when granted.
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 0;
      set_word(i, word(i, 0));
    end
    req = 4'hf;
    for (int n = 0; n < BD; n++) begin
      tick();
      p = n % NR;
      check("rr_grant", 32'(grant), 32'(1 << p));
      check("rr_push",  32'(fifo_push), 32'd1);
      check("rr_tail",  32'(fifo_tail), 32'(word(p, cnt[p])));
      check("rr_free",  32'(free_slots), 32'(22 - n));
      check("rr_full",  32'(full), 32'(n == 22));
      cnt[p]++;
      set_word(p, word(p, cnt[p]));
    end
    tick();
    check("full_grant", 32'(grant), 32'd0);
    check("full_push",  32'(fifo_push), 32'd0);
    check("full_tail",  32'(fifo_tail), 32'(word(2, 5)));
    check("full_free",  32'(free_slots), 32'd0);
    check("full_full",  32'(full), 32'd1);

    // Pull at full: credit returns this edge, grant only on the next.
    fifo_pull = 1'b1;
    tick();
    check("pull_free", 32'(free_slots), 32'd1);
    check("pull_nogrant", 32'(grant), 32'd0);
    fifo_pull = 1'b0;
    tick();
    check("resume_grant", 32'(grant), 32'd8);
    check("resume_tail",  32'(fifo_tail), 32'(word(3, 5)));
    check("resume_free",  32'(free_slots), 32'd0);
    check("resume_full",  32'(full), 32'd1);

    // Build up an active push, then assert reset mid-cycle.
    fifo_pull = 1'b1;
    tick();
    check("pre_rst_free",  32'(free_slots), 32'd1);
    check("pre_rst_grant", 32'(grant), 32'd0);
    tick();
    check("act_grant", 32'(grant), 32'd1);
    check("act_push",  32'(fifo_push), 32'd1);
    check("act_free",  32'(free_slots), 32'd1);
    #3 reset = 1'b0;
    #1;
    check("async_grant", 32'(grant), 32'd0);
    check("async_push",  32'(fifo_push), 32'd0);
    check("async_free",  32'(free_slots), 32'd23);
    check("async_full",  32'(full), 32'd0);
    fifo_pull = 1'b0;
    req       = '0;
    tick();
    reset = 1'b1;

    // Pull with credits at depth is ignored.
    fifo_pull = 1'b1;
    tick();
    check("empty_pull_free",  32'(free_slots), 32'd23);
    check("empty_pull_grant", 32'(grant), 32'd0);
    fifo_pull = 1'b0;

    // Single producer held high: grant every other cycle, no duplicate push.
    set_word(2, 23'h5a5a5);
    req = 4'b0100;
    for (int t = 0; t < 26; t++) begin
      tick();
      if (t % 2 == 0) begin
        check("solo_grant", 32'(grant), 32'd4);
        check("solo_push",  32'(fifo_push), 32'd1);
        check("solo_tail",  32'(fifo_tail), 32'h5a5a5);
      end else begin
        check("solo_mask_grant", 32'(grant), 32'd0);
        check("solo_mask_push",  32'(fifo_push), 32'd0);
      end
      check("solo_free", 32'(free_slots), 32'(22 - t / 2));
    end
    // Issue and pull together at 10 credits leaves the count unchanged.
    fifo_pull = 1'b1;
    tick();
    check("both_grant", 32'(grant), 32'd4);
    check("both_free",  32'(free_slots), 32'd10);
    fifo_pull = 1'b0;
    req = '0;

    // Producers 0 and 3: alternate in both builds.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req = 4'b1001;
    exp_seq = '{1, 8, 1, 8};
    for (int n = 0; n < 4; n++) begin
      tick();
      check("pair03_grant", 32'(grant), 32'(exp_seq[n]));
    end
    req = '0;

    // Producers 0, 1 and 3: priority build differs from plain round-robin.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req = 4'b1011;
`ifdef FIFO_ARB_PRIO0_EN
    exp_seq = '{1, 2, 1, 8};
`else
    exp_seq = '{1, 2, 8, 1};
`endif
    for (int n = 0; n < 4; n++) begin
      tick();
      check("tri_grant", 32'(grant), 32'(exp_seq[n]));
      check("tri_push",  32'(fifo_push), 32'd1);
    end
    check("tri_free", 32'(free_slots), 32'd19);
    req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
